// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry/borrow flop, LSB first, WIDTH cycles per operation.
// Latency: done pulses in the cycle after edge start+WIDTH; start is honoured only in IDLE.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               c;
  logic               mode_r;

  logic               bi;
  logic               s;
  logic               c_next;
  logic               last_bit;

  // Subtraction is a + ~b + 1: b is inverted per bit and the carry is preset to 1.
  always_comb begin
    bi       = b_sh[0] ^ mode_r;
    s        = a_sh[0] ^ bi ^ c;
    c_next   = (a_sh[0] & bi) | (c & (a_sh[0] ^ bi));
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      mode_r <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_r <= mode;
            c      <= mode;
            cnt    <= '0;
            acc    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc  <= {s, acc[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= c_next;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            // Borrow is the inverted carry in subtract mode.
            result <= {s, acc[WIDTH-1:1]};
            cout   <= c_next ^ mode_r;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and randomised checks of serial_add_sub against hand-computed values and a reference sum/difference.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int compared = 0;
  int mismatched = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: start pulse, then track busy length and done timing relative to the start edge.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tm, input logic [W-1:0] er, input logic ec);
    int busy_cyc;
    int done_at;
    int n;
    a = ta; b = tb_v; mode = tm; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
    busy_cyc = busy ? 1 : 0;
    done_at  = -1;
    n        = 0;
    while (done_at < 0 && n < 20) begin
      tick();
      n++;
      if (busy) busy_cyc++;
      if (done) done_at = n;
    end
    check({tag, " busy_cycles"}, busy_cyc, 8);
    check({tag, " done_edge"}, done_at, 8);
    check({tag, " result"}, result, er);
    check({tag, " cout"}, cout, ec);
    tick();
    check({tag, " done_one_cycle"}, done, 0);
  endtask

  initial begin
    logic [W:0] ref_v;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rm;
    int n;
    int done_cnt;
    int accepted;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset cout", cout, 0);
    rst_n = 1'b1;
    tick();

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b0);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b1);

    // start held high through RUN/DONE must not relaunch until IDLE.
    a = 8'h12; b = 8'h34; mode = 1'b0; start = 1'b1;
    tick();
    a = 8'hAA; b = 8'h55; mode = 1'b1;
    for (int i = 1; i < 8; i++) tick();
    check("hold result_stable_in_run", result, 8'hFF);
    tick();
    check("hold first_done", done, 1);
    check("hold first_result", result, 8'h46);
    check("hold first_cout", cout, 0);
    tick();
    check("hold done_idle_busy", busy, 0);
    tick();
    check("hold second_start_busy", busy, 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("hold second_done_edge", n, 8);
    check("hold second_result", result, 8'h55);
    check("hold second_cout", cout, 0);
    tick();

    // Asynchronous reset during the 4th RUN cycle aborts without a done pulse.
    a = 8'h80; b = 8'h80; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort cout", cout, 0);
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort no_done", done_cnt, 0);
    check("abort idle_result", result, 0);
    run_op("after_abort_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Back-to-back randomised operations against the reference sum/difference.
    done_cnt = 0;
    accepted = 0;
    for (int op = 0; op < 1000; op++) begin
      ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
      ref_v = rm ? ({1'b0, ra} - {1'b0, rb}) : ({1'b0, ra} + {1'b0, rb});
      a = ra; b = rb; mode = rm; start = 1'b1;
      tick();
      if (busy) accepted++;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
      n = 0;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      if (done) done_cnt++;
      check("rand result", result, ref_v[W-1:0]);
      check("rand cout", cout, ref_v[W]);
      tick();
      if (done) done_cnt++;
    end
    check("rand accepted", accepted, 1000);
    check("rand done_count", done_cnt, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
